// File: rtl/wbn_pkg.sv
// ============================================================================
// wbn_pkg : shared types for the Wishbone slave RAM
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

package wbn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_t;

  localparam int CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/wbn_ram.sv
// ============================================================================
// wbn_ram : DEPTH x DW storage, byte-enable synchronous write, synchronous read
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wbn_ram #(
  parameter int DW    = 32,
  parameter int SW    = DW / 8,
  parameter int DEPTH = 64,
  parameter int MAW   = 6
) (
  input  logic           clk_i,
  input  logic           we_i,
  input  logic           re_i,
  input  logic [SW-1:0]  be_i,
  input  logic [MAW-1:0] addr_i,
  input  logic [DW-1:0]  wdata_i,
  output logic [DW-1:0]  rdata_o
);

  localparam int BW = DW / SW;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < SW; i++) begin
        if (be_i[i]) mem_q[addr_i][i*BW +: BW] <= wdata_i[i*BW +: BW];
      end
    end
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/wbn_slv_ram.sv
// ============================================================================
// wbn_slv_ram : Wishbone classic slave RAM with programmable wait states
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module wbn_slv_ram
  import wbn_pkg::*;
#(
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int SW    = DW / 8,
  parameter int DEPTH = 64,
  parameter int WAIT  = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          cyc_i,
  input  logic          stb_i,
  input  logic          we_i,
  input  logic [AW-1:0] adr_i,
  input  logic [SW-1:0] sel_i,
  input  logic [DW-1:0] dat_w_i,
  output logic [DW-1:0] dat_r_o,
  output logic          ack_o,
  output logic          err_o,
  output logic          rty_o
);

  localparam int OB      = $clog2(SW);
  localparam int IW      = AW - OB;
  localparam int MAW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit NO_WAIT = (WAIT == 0);

  state_t           state_q;
  rsp_t             rsp_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic [IW-1:0]    idx_q;
  logic [SW-1:0]    sel_q;
  logic [DW-1:0]    dat_q;
  logic             rd_zero_q;

  logic             req;
  logic             in_idle;
  logic             cur_we;
  logic [IW-1:0]    cur_idx;
  logic [SW-1:0]    cur_sel;
  logic [DW-1:0]    cur_dat;
  logic             cur_err;
  logic             go_resp;
  logic             ram_we;
  logic             ram_re;
  logic [DW-1:0]    ram_rdata;
  logic             unused_adr;

  assign req     = cyc_i & stb_i;
  assign in_idle = (state_q == ST_IDLE);

  // With zero wait states the accepting edge is also the RESP edge, so the
  // live bus fields must be used there; otherwise the latched copy is used.
  assign cur_we  = in_idle ? we_i              : we_q;
  assign cur_idx = in_idle ? adr_i[AW-1:OB]    : idx_q;
  assign cur_sel = in_idle ? sel_i             : sel_q;
  assign cur_dat = in_idle ? dat_w_i           : dat_q;
  assign cur_err = (cur_idx >= IW'(DEPTH)) || (cur_sel == '0);

  assign go_resp = rst_ni & req &
                   ((in_idle & NO_WAIT) | ((state_q == ST_WAIT) & (cnt_q == '0)));
  assign ram_we  = go_resp &  cur_we & ~cur_err;
  assign ram_re  = go_resp & ~cur_we & ~cur_err;

  assign unused_adr = ^adr_i[OB-1:0];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      rsp_q     <= RSP_NONE;
      cnt_q     <= '0;
      we_q      <= 1'b0;
      idx_q     <= '0;
      sel_q     <= '0;
      dat_q     <= '0;
      rd_zero_q <= 1'b1;
    end else begin
      rsp_q <= RSP_NONE;
      if (go_resp && !cur_we) rd_zero_q <= cur_err;
      case (state_q)
        ST_IDLE: begin
          if (req) begin
            we_q  <= we_i;
            idx_q <= adr_i[AW-1:OB];
            sel_q <= sel_i;
            dat_q <= dat_w_i;
            if (NO_WAIT) begin
              state_q <= ST_RESP;
              rsp_q   <= cur_err ? RSP_ERR : RSP_ACK;
            end else begin
              state_q <= ST_WAIT;
              cnt_q   <= CNT_W'(WAIT - 1);
            end
          end
        end
        ST_WAIT: begin
          if (!req) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= ST_RESP;
            rsp_q   <= cur_err ? RSP_ERR : RSP_ACK;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  wbn_ram #(
    .DW    (DW),
    .SW    (SW),
    .DEPTH (DEPTH),
    .MAW   (MAW)
  ) u_ram (
    .clk_i   (clk_i),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .be_i    (cur_sel),
    .addr_i  (cur_idx[MAW-1:0]),
    .wdata_i (cur_dat),
    .rdata_o (ram_rdata)
  );

  // Read data register is the RAM output; rd_zero_q masks it to 0 after
  // reset and after an errored read, and holds across write responses.
  assign dat_r_o = rd_zero_q ? '0 : ram_rdata;
  assign ack_o   = (rsp_q == RSP_ACK);
  assign err_o   = (rsp_q == RSP_ERR);
  assign rty_o   = 1'b0;

endmodule

`default_nettype wire

// File: tb/tb_wbn_slv_ram.sv
// ============================================================================
// tb_wbn_slv_ram : scoreboard bench for wbn_slv_ram at WAIT = 1, 3 and 0
// Rev 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_wbn_slv_ram;

  typedef struct {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
    int          due;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        cyc   [3];
  logic        stb   [3];
  logic        we    [3];
  logic [31:0] adr   [3];
  logic [3:0]  sel   [3];
  logic [31:0] dw    [3];
  logic [31:0] dr    [3];
  logic        ack   [3];
  logic        err   [3];
  logic        rty   [3];

  int   cyc_cnt;
  int   checks;
  int   errors;
  exp_t sbq [3][$];

  wbn_slv_ram #(.AW(32), .DW(32), .SW(4), .DEPTH(64), .WAIT(1)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]),
    .adr_i(adr[0]), .sel_i(sel[0]), .dat_w_i(dw[0]), .dat_r_o(dr[0]),
    .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0]));

  wbn_slv_ram #(.AW(32), .DW(32), .SW(4), .DEPTH(64), .WAIT(3)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]),
    .adr_i(adr[1]), .sel_i(sel[1]), .dat_w_i(dw[1]), .dat_r_o(dr[1]),
    .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1]));

  wbn_slv_ram #(.AW(32), .DW(32), .SW(4), .DEPTH(64), .WAIT(0)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .cyc_i(cyc[2]), .stb_i(stb[2]), .we_i(we[2]),
    .adr_i(adr[2]), .sel_i(sel[2]), .dat_w_i(dw[2]), .dat_r_o(dr[2]),
    .ack_o(ack[2]), .err_o(err[2]), .rty_o(rty[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int wait_of(input int d);
    case (d)
      0:       return 1;
      1:       return 3;
      default: return 0;
    endcase
  endfunction

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end
  endtask

  // Monitor: every ack/err pops one expectation for that DUT.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 3; d++) begin
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        checks++;
        if (sbq[d].size() == 0) begin
          errors++;
          $display("FAIL unexpected_rsp dut%0d: got ack=%0b err=%0b, required no response",
                   d, ack[d], err[d]);
        end else begin
          e = sbq[d].pop_front();
          if (ack[d] !== !e.is_err || err[d] !== e.is_err) begin
            errors++;
            $display("FAIL rsp_kind dut%0d: got ack=%0b err=%0b, required ack=%0b err=%0b",
                     d, ack[d], err[d], !e.is_err, e.is_err);
          end
          checks++;
          if (cyc_cnt != e.due) begin
            errors++;
            $display("FAIL latency dut%0d: got cycle %0d, required cycle %0d",
                     d, cyc_cnt, e.due);
          end
          if (e.chk_dat) begin
            checks++;
            if (dr[d] !== e.dat) begin
              errors++;
              $display("FAIL rdata dut%0d: got 0x%08h, required 0x%08h", d, dr[d], e.dat);
            end
          end
        end
      end
    end
  end

  // Called at a negedge. lead = edges until the accepting edge (2 when the
  // DUT is in its RESP cycle). hold keeps cyc/stb high after the response.
  task automatic xfer(input int d, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] wd,
                      input logic exp_err, input logic [31:0] exp_d,
                      input int lead, input bit hold);
    exp_t e;
    bit   seen;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w;
    adr[d] = a; sel[d] = s; dw[d] = wd;
    e.is_err  = exp_err;
    e.chk_dat = !w;
    e.dat     = exp_d;
    e.due     = cyc_cnt + lead + wait_of(d);
    sbq[d].push_back(e);
    seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d: got no ack/err, required a response within 64 cycles", d);
    end
    if (!hold) begin
      cyc[d] = 1'b0; stb[d] = 1'b0;
      @(negedge clk);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int d = 0; d < 3; d++) begin
      cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      adr[d] = '0; sel[d] = '0; dw[d] = '0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check32("reset_ack",   {31'd0, ack[d]}, 32'd0);
      check32("reset_err",   {31'd0, err[d]}, 32'd0);
      check32("reset_rty",   {31'd0, rty[d]}, 32'd0);
      check32("reset_dat_r", dr[d],           32'd0);
    end
    rst_n = 1'b1;

    // WAIT=1: basic write/read, accepted at the first edge after reset release
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEADBEEF, 1'b0, 32'h0,        1, 0);
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1, 0);
    // Byte-lane write over a preloaded word
    xfer(0, 1'b1, 32'h4,  4'hF, 32'h11223344, 1'b0, 32'h0,        1, 0);
    xfer(0, 1'b1, 32'h4,  4'h2, 32'h0000AA00, 1'b0, 32'h0,        1, 0);
    xfer(0, 1'b0, 32'h4,  4'hF, 32'h0,        1'b0, 32'h1122AA44, 1, 0);
    // Out-of-range read and sel=0 write both error; memory unchanged
    xfer(0, 1'b0, 32'h100, 4'hF, 32'h0,        1'b1, 32'h0,        1, 0);
    xfer(0, 1'b1, 32'h10,  4'h0, 32'h01020304, 1'b1, 32'h0,        1, 0);
    xfer(0, 1'b0, 32'h13,  4'hF, 32'h0,        1'b0, 32'hDEADBEEF, 1, 0);
    // Last valid word
    xfer(0, 1'b1, 32'hFC, 4'hF, 32'hCAFEF00D, 1'b0, 32'h0,        1, 0);
    xfer(0, 1'b0, 32'hFC, 4'hF, 32'h0,        1'b0, 32'hCAFEF00D, 1, 0);

    // WAIT=3: abort after one wait cycle, then readback proves no write
    xfer(1, 1'b1, 32'h20, 4'hF, 32'h0BADF00D, 1'b0, 32'h0, 1, 0);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1;
    adr[1] = 32'h20; sel[1] = 4'hF; dw[1] = 32'h12345678;
    repeat (2) @(negedge clk);
    stb[1] = 1'b0;
    @(negedge clk);
    cyc[1] = 1'b0; dw[1] = 32'h0;
    repeat (6) @(negedge clk);
    xfer(1, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, 32'h0BADF00D, 1, 0);

    // WAIT=0: preload, then four back-to-back reads with stb held
    xfer(2, 1'b1, 32'h0, 4'hF, 32'hA0A0A0A0, 1'b0, 32'h0, 1, 0);
    xfer(2, 1'b1, 32'h4, 4'hF, 32'hB1B1B1B1, 1'b0, 32'h0, 1, 0);
    xfer(2, 1'b1, 32'h8, 4'hF, 32'hC2C2C2C2, 1'b0, 32'h0, 1, 0);
    xfer(2, 1'b1, 32'hC, 4'hF, 32'hD3D3D3D3, 1'b0, 32'h0, 1, 0);
    xfer(2, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0, 32'hA0A0A0A0, 1, 1);
    xfer(2, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, 32'hB1B1B1B1, 2, 1);
    xfer(2, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, 32'hC2C2C2C2, 2, 1);
    xfer(2, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, 32'hD3D3D3D3, 2, 0);

    // WAIT=1: reset asserted while a write sits in WAIT
    xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, 32'hDEADBEEF, 1, 0);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1;
    adr[0] = 32'h4; sel[0] = 4'hF; dw[0] = 32'h55555555;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check32("rst_mid_ack",   {31'd0, ack[0]}, 32'd0);
    check32("rst_mid_err",   {31'd0, err[0]}, 32'd0);
    check32("rst_mid_dat_r", dr[0],           32'd0);
    @(negedge clk);
    cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    xfer(0, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, 32'h1122AA44, 1, 0);

    repeat (4) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check32("pending_rsp", sbq[d].size(), 32'd0);
      check32("rty_const",   {31'd0, rty[d]}, 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/wbn_slv_ram.md
WBN_SLV_RAM -- requirements
Module: wbn_slv_ram

Interface
REQ-001 Parameter AW, default 32, address width in bits.
REQ-002 Parameter DW, default 32, data width in bits.
REQ-003 Parameter SW, default DW/8, byte select width.
REQ-004 Parameter DEPTH, default 64, number of DW-bit words stored.
REQ-005 Parameter WAIT, default 1, wait states inserted before each response (0..15).
REQ-006 clk  input  1  clock, rising edge active; one clock only.
REQ-007 rst  input  1  reset, asynchronous, active-low.
REQ-008 cyc  input  1  Wishbone cycle.
REQ-009 stb  input  1  transfer strobe.
REQ-010 we  input  1  write enable.
REQ-011 adr  input  AW  byte address.
REQ-012 sel  input  SW  byte select.
REQ-013 dat_w  input  DW  write data.
REQ-014 dat_r  output  DW  read data.
REQ-015 ack  output  1  acknowledge.
REQ-016 err  output  1  error.
REQ-017 rty  output  1  retry; constant 0.

Function
REQ-018 Word index = adr[AW-1:log2(SW)]; adr[log2(SW)-1:0] ignored.
REQ-019 Request = cyc & stb sampled at a rising edge while in IDLE.
REQ-020 FSM states IDLE, WAIT, RESP; reset state IDLE.
REQ-021 IDLE -> WAIT on request when WAIT>0, loading the wait counter with WAIT-1; IDLE -> RESP on request when WAIT=0.
REQ-022 WAIT: counter decrements each cycle; WAIT -> RESP when counter = 0 and cyc & stb still high.
REQ-023 WAIT -> IDLE if cyc or stb is low at any edge (abort): no write, no response, counter discarded.
REQ-024 Request fields (we, adr, sel, dat_w) are latched at the accepting edge; later changes are ignored.
REQ-025 Error condition: word index >= DEPTH, or sel = 0.
REQ-026 RESP lasts exactly one cycle: ack=1 if no error, else err=1; never both; RESP -> IDLE unconditionally.
REQ-027 ack/err are registered outputs, 0 in every state other than RESP.
REQ-028 Latency from the accepting edge to the ack/err high cycle: WAIT+1 cycles.
REQ-029 Write: memory updated at the edge entering RESP, only bytes with sel[i]=1, only when no error.
REQ-030 Read: dat_r loaded at the edge entering RESP with the word at the latched index; loaded with 0 on error.
REQ-031 dat_r holds its value outside RESP until the next read response.
REQ-032 Back-to-back: cyc & stb high in the cycle after RESP is a new request accepted from IDLE; minimum 2 cycles per transfer.
REQ-033 Write errors leave memory unchanged.

Reset
REQ-034 rst low forces IDLE, ack=0, err=0, rty=0, dat_r=0, counter=0 immediately, independent of clk.
REQ-035 Reset mid-transfer discards the transfer; pending writes are not committed.
REQ-036 Memory contents are not reset; reads of unwritten words return X in simulation.
REQ-037 First request accepted at the first rising edge after rst deasserts.

Structure
REQ-038 Package wbn_pkg holds the FSM state enum (IDLE, WAIT, RESP) and the response enum (NONE, ACK, ERR).
REQ-039 Storage is sub-module wbn_ram: DEPTH x DW, synchronous byte-enable write, synchronous read, no reset.
REQ-040 FSM, wait counter, decode and request latch live in wbn_slv_ram.

Verification
REQ-041 WAIT=1: write adr=0x10, sel=0xF, dat_w=0xDEADBEEF; read adr=0x10 -> ack 2 cycles after each accept, dat_r=0xDEADBEEF, err=0.
REQ-042 Preload 0x11223344 at adr=0x4; write sel=0x2, dat_w=0x0000AA00; read -> dat_r=0x1122AA44.
REQ-043 DEPTH=64: read adr=0x100 (index 64) -> err=1 one cycle, ack=0, dat_r=0; write with sel=0 -> err=1, memory unchanged.
REQ-044 WAIT=3: write then drop stb after 1 wait cycle -> no ack/err, FSM IDLE; readback shows old data.
REQ-045 WAIT=0: 4 back-to-back reads with stb held -> ack every other cycle, latency 1, correct data each.
REQ-046 Assert rst low during WAIT of a write -> outputs 0 immediately; after release, readback shows old data.
